regfile_scan_reader: RTL and testbench

Sequential read-side initiator for the 32 x 32-bit general-purpose register file. On a start pulse it walks a programmable address range over one combinational register-file read port and streams each (address, data) pair out on a valid/ready interface. It serves as the debug/state-dump path next to the CPU datapath, with pipeline stalls applied by the consumer through out_ready.

---
 rtl/regfile_scan_pkg.sv | 18 +
 rtl/regfile_scan_ostage.sv | 52 +++++
 rtl/regfile_scan_reader.sv | 109 ++++++++++
 tb/tb_regfile_scan_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scan_pkg.sv
// Shared definitions for the register-file scan reader.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   NUM_REGS                : number of general-purpose registers
//   scan_state_e            : scan FSM states
package regfile_scan_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/regfile_scan_ostage.sv
// Single-entry valid/ready output register for the scan reader.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_load        : capture i_addr/i_data and mark the entry valid
//   i_abort       : drop the held word (wins over load)
//   i_addr/i_data : word to capture
//   i_ready       : consumer ready
//   o_valid/o_addr/o_data : held word
//   o_free        : entry can take a new word this cycle (empty or draining)
module regfile_scan_ostage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_free
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_abort) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      // A load on a handshake edge replaces the departing word.
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/regfile_scan_reader.sv
// Sequential read-side initiator for the GPR file: on start, walks
// first_addr..last_addr (wrapping mod 32) over one combinational read
// port and streams (addr, data) pairs on a valid/ready interface.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, abort           : scan request (IDLE only) / synchronous cancel
//   first_addr, last_addr  : scan range, sampled with start
//   rf_addr, rf_data       : register-file read port
//   out_valid/ready/addr/data : output stream
//   busy, done             : scan in progress / one-cycle completion pulse
module regfile_scan_reader
  import regfile_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  scan_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur, w_cur_nxt;
  logic [ADDR_W-1:0] r_end, w_end_nxt;
  logic              w_load;
  logic              w_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_end   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_end   <= w_end_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_end_nxt   = r_end;
    w_load      = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_SCAN;
            w_cur_nxt   = first_addr;
            w_end_nxt   = last_addr;
          end
        end
        ST_SCAN: begin
          if (w_free) begin
            w_load    = 1'b1;
            // Counter width makes the increment wrap 31 -> 0.
            w_cur_nxt = r_cur + 1'b1;
            // Stopping on cur == end bounds a scan to at most 32 words.
            if (r_cur == r_end) w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  regfile_scan_ostage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ostage (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_abort (abort),
    .i_addr  (r_cur),
    .i_data  (rf_data),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_addr  (out_addr),
    .o_data  (out_data),
    .o_free  (w_free)
  );

  assign rf_addr = r_cur;
  assign busy    = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_regfile_scan_reader.sv
module tb_regfile_scan_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] gpr [32];
  int n_cmp = 0;
  int n_err = 0;

  assign rf_data = gpr[rf_addr];

  regfile_scan_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".rf_addr"},   64'(rf_addr),   64'd0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_addr"},  64'(out_addr),  64'd0);
    chk({tag, ".out_data"},  64'(out_data),  64'd0);
    chk({tag, ".busy"},      64'(busy),      64'd0);
    chk({tag, ".done"},      64'(done),      64'd0);
  endtask

  // Pulse start; returns in cycle 1 (first cycle after the start edge).
  task automatic start_scan(input logic [4:0] f, input logic [4:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Consume words until done, checking order/data against the gpr model.
  // cyc0 is the current cycle number relative to the start edge.
  task automatic consume(input string tag, input logic [4:0] f, input int idx0,
                         input int cyc0, output int words, output int done_cyc,
                         output int busy_cyc);
    logic [4:0] a;
    int cyc;
    words    = idx0;
    done_cyc = -1;
    busy_cyc = 0;
    cyc      = cyc0;
    while (cyc < 200) begin
      if (busy) busy_cyc++;
      if (out_valid && out_ready) begin
        a = f + 5'(words);
        chk({tag, ".addr"}, 64'(out_addr), 64'(a));
        chk({tag, ".data"}, 64'(out_data), 64'(gpr[a]));
        words++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    chk({tag, ".done_seen"}, 64'(done_cyc >= 0), 64'd1);
    if (done_cyc >= 0) begin
      tick();
      chk({tag, ".done_1cyc"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int words, dcyc, bcyc;
    for (int i = 0; i < 32; i++) gpr[i] = 32'(i * 3);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();
    chk_reset_outs("idle");

    // Full scan 0..31: words in cycles 2..33, done in 34, busy 1..33
    start_scan(5'd0, 5'd31);
    chk("full.c1_busy", 64'(busy), 64'd1);
    chk("full.c1_rf_addr", 64'(rf_addr), 64'd0);
    chk("full.c1_valid", 64'(out_valid), 64'd0);
    consume("full", 5'd0, 0, 1, words, dcyc, bcyc);
    chk("full.words", 64'(words), 64'd32);
    chk("full.done_cyc", 64'(dcyc), 64'd34);
    chk("full.busy_cyc", 64'(bcyc), 64'd33);

    // Wrap 30..1
    start_scan(5'd30, 5'd1);
    chk("wrap.c1_rf_addr", 64'(rf_addr), 64'd30);
    consume("wrap", 5'd30, 0, 1, words, dcyc, bcyc);
    chk("wrap.words", 64'(words), 64'd4);
    chk("wrap.done_cyc", 64'(dcyc), 64'd6);

    // Single word 7
    gpr[7] = 32'hDEADBEEF;
    start_scan(5'd7, 5'd7);
    consume("single", 5'd7, 0, 1, words, dcyc, bcyc);
    chk("single.words", 64'(words), 64'd1);
    chk("single.busy_cyc", 64'(bcyc), 64'd2);
    chk("single.done_cyc", 64'(dcyc), 64'd3);
    gpr[7] = 32'd21;

    // Backpressure: ready low for 5 cycles once word 0 is valid
    start_scan(5'd0, 5'd31);
    tick();
    chk("bp.c2_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold_valid", 64'(out_valid), 64'd1);
      chk("bp.hold_addr", 64'(out_addr), 64'd0);
      chk("bp.hold_data", 64'(out_data), 64'd0);
      chk("bp.hold_rf_addr", 64'(rf_addr), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    consume("bp", 5'd0, 0, 7, words, dcyc, bcyc);
    chk("bp.words", 64'(words), 64'd32);
    chk("bp.done_cyc", 64'(dcyc), 64'd39);

    // Abort in SCAN with a valid word pending
    start_scan(5'd0, 5'd31);
    tick();
    tick();
    chk("abort.pre_valid", 64'(out_valid), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.valid", 64'(out_valid), 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort.no_done", 64'(done), 64'd0);
      chk("abort.idle", 64'(busy), 64'd0);
    end
    start_scan(5'd5, 5'd6);
    chk("abort.rs_rf_addr", 64'(rf_addr), 64'd5);
    consume("abort.rs", 5'd5, 0, 1, words, dcyc, bcyc);
    chk("abort.rs_words", 64'(words), 64'd2);

    // Asynchronous reset while word 10 is held (cycle 12)
    start_scan(5'd0, 5'd31);
    for (int k = 0; k < 11; k++) tick();
    chk("arst.pre_addr", 64'(out_addr), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    start = 1'b1;
    tick();
    tick();
    chk_reset_outs("arst.held");
    start = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst.after_busy", 64'(busy), 64'd0);
    start_scan(5'd0, 5'd31);
    consume("arst.full", 5'd0, 0, 1, words, dcyc, bcyc);
    chk("arst.words", 64'(words), 64'd32);
    chk("arst.done_cyc", 64'(dcyc), 64'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
